i2s_tx_fifo: RTL and testbench



---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_frame_fifo.sv | 64 ++++++
 rtl/i2s_tx_fifo.sv | 137 +++++++++++++
 tb/tb_i2s_tx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample and slot widths, the stereo
// frame type and the I2S word-select polarity.
package audio_pkg;

    localparam int AUDIO_DATA_BITS = 24;
    localparam int I2S_SLOT_BITS   = 32;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef struct packed {
        logic [AUDIO_DATA_BITS-1:0] left;
        logic [AUDIO_DATA_BITS-1:0] right;
    } audio_frame_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous show-ahead FIFO of stereo frames. A write is judged against the
// level at the start of the cycle, so a same-cycle pop never makes room for it.
module audio_frame_fifo #(
    parameter int WIDTH      = 48,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LEVEL_W = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = LEVEL_W'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  wr_ok, rd_ok;

    assign full    = (level_q == LEVEL_FULL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        wr_ok    = wr_en && !full;
        rd_ok    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok)      level_d = level_q + 1'b1;
        else if (rd_ok && !wr_ok) level_d = level_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/i2s_tx_fifo.sv
// Stereo Philips-I2S transmitter: frame FIFO, AMCLK-derived BCK/WS and an
// MSB-first serializer that replays the last frame when the FIFO runs dry.
module i2s_tx_fifo
    import audio_pkg::*;
#(
    parameter int DATA_BITS       = AUDIO_DATA_BITS,
    parameter int SLOT_BITS       = I2S_SLOT_BITS,
    parameter int MCLK_DIV        = 4,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     AMCLK_i,
    input  logic                     ARST_i,
    input  logic [DATA_BITS-1:0]     APDATA_LEFT_i,
    input  logic [DATA_BITS-1:0]     APDATA_RIGHT_i,
    input  logic                     APDATA_VALID_i,
    output logic [FIFO_DEPTH_LOG2:0] FIFO_LEVEL_o,
    output logic                     UNDERRUN_o,
    output logic                     OVERFLOW_o,
    output logic                     I2S_BCK,
    output logic                     I2S_WS,
    output logic                     I2S_DATA
);

    localparam int DIV_W = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(DATA_BITS);

    typedef struct packed {
        logic [DATA_BITS-1:0] left;
        logic [DATA_BITS-1:0] right;
    } frame_t;

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 bck_q, bck_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 ws_q, ws_d;
    logic                 data_q, data_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    frame_t               frame_q, frame_d;
    logic                 underrun_q, underrun_d;
    logic                 overflow_q, overflow_d;
    logic [BIT_W-1:0]     pos;
    logic                 pop;
    logic                 fifo_full, fifo_empty;
    frame_t               fifo_rd_data;

    audio_frame_fifo #(
        .WIDTH      (2 * DATA_BITS),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (AMCLK_i),
        .rst     (ARST_i),
        .wr_en   (APDATA_VALID_i),
        .wr_data ({APDATA_LEFT_i, APDATA_RIGHT_i}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (FIFO_LEVEL_o)
    );

    always_comb begin
        div_d      = div_q + 1'b1;
        bck_d      = bck_q;
        bit_d      = bit_q;
        ws_d       = ws_q;
        data_d     = data_q;
        shift_d    = shift_q;
        frame_d    = frame_q;
        underrun_d = 1'b0;
        overflow_d = APDATA_VALID_i && fifo_full;
        pos        = '0;
        pop        = 1'b0;

        if (div_q == DIV_LAST) begin
            div_d = '0;
            bck_d = ~bck_q;
            if (bck_q) begin
                bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
                ws_d  = (bit_d >= SLOT_LEN) ? WS_RIGHT : WS_LEFT;
                pos   = (ws_d == WS_RIGHT) ? bit_d - SLOT_LEN : bit_d;

                // frame_q serves as both shadow and replay: an empty boundary simply keeps it
                if (bit_d == '0) begin
                    if (fifo_empty) underrun_d = 1'b1;
                    else begin
                        pop     = 1'b1;
                        frame_d = fifo_rd_data;
                    end
                end

                // Slot bit 0 is the one-BCK delay after WS; the channel word shifts out from bit 1
                data_d = 1'b0;
                if (pos == '0) begin
                    shift_d = (ws_d == WS_RIGHT) ? frame_d.right : frame_d.left;
                end else if (pos <= DATA_LEN) begin
                    data_d  = shift_q[DATA_BITS-1];
                    shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge AMCLK_i) begin
        if (ARST_i) begin
            div_q      <= '0;
            bck_q      <= 1'b0;
            bit_q      <= BIT_LAST;
            ws_q       <= WS_LEFT;
            data_q     <= 1'b0;
            shift_q    <= '0;
            frame_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bck_q      <= bck_d;
            bit_q      <= bit_d;
            ws_q       <= ws_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign I2S_BCK    = bck_q;
    assign I2S_WS     = ws_q;
    assign I2S_DATA   = data_q;
    assign UNDERRUN_o = underrun_q;
    assign OVERFLOW_o = overflow_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Self-checking bench for i2s_tx_fifo: a time-based behavioural model checked
// every cycle, plus an I2S receiver whose decoded slots pin literal values.
`timescale 1ns/1ps
module tb_i2s_tx_fifo;
    import audio_pkg::*;

    localparam int DB         = AUDIO_DATA_BITS;
    localparam int SB         = I2S_SLOT_BITS;
    localparam int DIV        = 4;
    localparam int FLOG       = 2;
    localparam int DEPTH      = 1 << FLOG;
    localparam int BCK_PERIOD = 2 * DIV;
    localparam int FRAME      = 2 * SB * BCK_PERIOD;
    localparam int PRE_FRAME  = BCK_PERIOD - 2;   // phase just before each frame boundary

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          valid = 1'b0;
    logic [DB-1:0] left = '0, right = '0;
    logic [FLOG:0] level;
    logic          und, ovf, bck, ws, sdata;

    i2s_tx_fifo #(
        .DATA_BITS       (DB),
        .SLOT_BITS       (SB),
        .MCLK_DIV        (DIV),
        .FIFO_DEPTH_LOG2 (FLOG)
    ) dut (
        .AMCLK_i        (clk),
        .ARST_i         (arst),
        .APDATA_LEFT_i  (left),
        .APDATA_RIGHT_i (right),
        .APDATA_VALID_i (valid),
        .FIFO_LEVEL_o   (level),
        .UNDERRUN_o     (und),
        .OVERFLOW_o     (ovf),
        .I2S_BCK        (bck),
        .I2S_WS         (ws),
        .I2S_DATA       (sdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: t counts clock edges since reset; FIFO is a queue,
    // cur is the frame currently on the wire.
    audio_frame_t model_q[$];
    audio_frame_t cur;
    audio_frame_t wr_frame;
    int           t = 0;
    int           size_pre;
    int           k_fall;
    bit           model_ok = 1'b0;
    bit           exp_und = 1'b0, exp_ovf = 1'b0;

    always @(posedge clk) begin
        if (arst) begin
            model_q.delete();
            cur      = '0;
            t        = 0;
            exp_und  = 1'b0;
            exp_ovf  = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            t++;
            exp_und  = 1'b0;
            exp_ovf  = 1'b0;
            size_pre = model_q.size();
            k_fall   = t / BCK_PERIOD;
            if ((t % BCK_PERIOD) == 0 && ((k_fall - 1) % (2 * SB)) == 0) begin
                if (size_pre != 0) cur = model_q.pop_front();
                else exp_und = 1'b1;
            end
            if (valid) begin
                if (size_pre < DEPTH) begin
                    wr_frame.left  = left;
                    wr_frame.right = right;
                    model_q.push_back(wr_frame);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    end

    // Receiver state: decoded slots as a real I2S sink would see them on rising BCK.
    typedef struct {
        logic          ws;
        logic [DB-1:0] word;
        logic          pad_ok;
    } slot_t;

    slot_t         rx_q[$];
    slot_t         rx_slot;
    int            rx_pos = -2;
    logic          rx_prev_ws = 1'b0;
    logic [DB-1:0] rx_word = '0;
    logic          rx_pad_ok = 1'b1;
    logic          last_bck = 1'b0;
    int            und_cnt = 0;

    logic          e_bck, e_ws, e_data;
    int            e_k, e_b, e_p;
    logic [DB-1:0] e_word;

    always @(negedge clk) begin
        if (model_ok) begin
            e_bck  = ((t / DIV) % 2) == 1;
            e_ws   = 1'b0;
            e_data = 1'b0;
            if (t >= BCK_PERIOD) begin
                e_k    = t / BCK_PERIOD;
                e_b    = (e_k - 1) % (2 * SB);
                e_ws   = (e_b >= SB);
                e_p    = e_b % SB;
                e_word = e_ws ? cur.right : cur.left;
                if (e_p >= 1 && e_p <= DB) e_data = e_word[DB-e_p];
            end
            check($sformatf("outputs{bck,ws,data,und,ovf,level} t=%0d", t),
                  {bck, ws, sdata, und, ovf, level},
                  {e_bck, e_ws, e_data, exp_und, exp_ovf, 3'(model_q.size())});

            // One stray rise precedes the first frame after reset, hence the start at -2.
            if (t == 0) begin
                rx_q.delete();
                rx_pos     = -2;
                rx_prev_ws = 1'b0;
            end else if (bck && !last_bck) begin
                if (ws != rx_prev_ws) rx_pos = 0;
                else rx_pos++;
                rx_prev_ws = ws;
                if (rx_pos == 0) begin
                    rx_word   = '0;
                    rx_pad_ok = !sdata;
                end else if (rx_pos >= 1 && rx_pos <= DB) begin
                    rx_word = {rx_word[DB-2:0], sdata};
                end else if (sdata) begin
                    rx_pad_ok = 1'b0;
                end
                if (rx_pos == SB - 1) begin
                    rx_slot.ws     = rx_prev_ws;
                    rx_slot.word   = rx_word;
                    rx_slot.pad_ok = rx_pad_ok;
                    rx_q.push_back(rx_slot);
                end
            end
            last_bck = bck;
            if (und) und_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while ((t % FRAME) != ph && n < 2 * FRAME);
        if ((t % FRAME) != ph) check("wait_phase timeout", 64'(t % FRAME), 64'(ph));
    endtask

    task automatic do_reset(input int n);
        arst = 1'b1;
        tick(n);
        arst = 1'b0;
    endtask

    task automatic write(input logic [DB-1:0] l, input logic [DB-1:0] r);
        valid = 1'b1;
        left  = l;
        right = r;
        tick(1);
        valid = 1'b0;
    endtask

    task automatic check_frame(input string name, input int idx,
                               input logic [DB-1:0] l, input logic [DB-1:0] r);
        if (rx_q.size() < idx + 2) begin
            check({name, " decoded slots"}, 64'(rx_q.size()), 64'(idx + 2));
        end else begin
            check({name, " left{ws,pad_ok,word}"},
                  {rx_q[idx].ws, rx_q[idx].pad_ok, rx_q[idx].word}, {1'b0, 1'b1, l});
            check({name, " right{ws,pad_ok,word}"},
                  {rx_q[idx+1].ws, rx_q[idx+1].pad_ok, rx_q[idx+1].word}, {1'b1, 1'b1, r});
        end
    endtask

    initial begin
        int           base;
        int           u0;
        logic [DB-1:0] fl [5];
        logic [DB-1:0] fr [5];

        // Reset release: outputs idle, first BCK rise four cycles later, first frame silent.
        do_reset(3);
        check("reset outputs", {bck, ws, sdata, und, ovf, level}, 0);
        tick(3);
        check("bck low at cycle 3", bck, 0);
        tick(1);
        check("first bck rise at cycle 4", bck, 1);
        wait_phase(PRE_FRAME);
        base = rx_q.size();
        u0   = und_cnt;
        wait_phase(PRE_FRAME);
        check_frame("first frame zeros", base, '0, '0);
        check("underrun on empty first boundary", 64'(und_cnt - u0), 1);

        // Single frame written before the first boundary, then repeated on underrun.
        do_reset(1);
        tick(2);
        write(24'hA5A5A5, 24'h5A5A5A);
        check("level after single write", level, 1);
        wait_phase(PRE_FRAME);
        base = rx_q.size();
        u0   = und_cnt;
        wait_phase(PRE_FRAME);
        check_frame("frame A5/5A", base, 24'hA5A5A5, 24'h5A5A5A);
        check("no underrun with data queued", 64'(und_cnt - u0), 0);
        u0 = und_cnt;
        wait_phase(PRE_FRAME);
        check_frame("replayed A5/5A", base + 2, 24'hA5A5A5, 24'h5A5A5A);
        check("one underrun per frame", 64'(und_cnt - u0), 1);
        u0 = und_cnt;
        wait_phase(PRE_FRAME);
        check("one underrun next frame", 64'(und_cnt - u0), 1);

        // Overflow: five back-to-back writes into an empty FIFO.
        wait_phase(20);
        for (int i = 0; i < 5; i++) begin
            fl[i] = DB'($urandom);
            fr[i] = DB'($urandom);
            valid = 1'b1;
            left  = fl[i];
            right = fr[i];
            tick(1);
            check($sformatf("level after write %0d", i + 1), level, (i < 4) ? i + 1 : 4);
            check($sformatf("overflow after write %0d", i + 1), ovf, (i == 4) ? 1 : 0);
        end
        valid = 1'b0;
        tick(1);
        check("overflow is a single pulse", ovf, 0);
        wait_phase(PRE_FRAME);
        base = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            wait_phase(PRE_FRAME);
            check_frame($sformatf("queued frame %0d", i + 1), base + 2 * i,
                        fl[(i < 4) ? i : 3], fr[(i < 4) ? i : 3]);
        end

        // Write landing on the boundary cycle while one frame is stored.
        wait_phase(100);
        write(24'h123456, 24'h654321);
        wait_phase(PRE_FRAME);
        base = rx_q.size();
        tick(1);
        valid = 1'b1;
        left  = 24'hC0FFEE;
        right = 24'h00BEEF;
        tick(1);
        valid = 1'b0;
        check("level after write+pop", level, 1);
        check("no underrun on write+pop", und, 0);
        wait_phase(PRE_FRAME);
        check_frame("popped frame", base, 24'h123456, 24'h654321);
        wait_phase(PRE_FRAME);
        check_frame("frame written at boundary", base + 2, 24'hC0FFEE, 24'h00BEEF);

        // Random traffic: sparse writes, then a dense burst that keeps the FIFO full.
        for (int i = 0; i < 20 * FRAME; i++) begin
            valid = ($urandom_range(0, 149) == 0);
            left  = DB'($urandom);
            right = DB'($urandom);
            tick(1);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            valid = ($urandom_range(0, 7) == 0);
            left  = DB'($urandom);
            right = DB'($urandom);
            tick(1);
        end
        valid = 1'b0;

        // Reset mid-frame at left-slot bit 10 with three frames queued.
        repeat (DEPTH + 1) wait_phase(PRE_FRAME);
        check("fifo drained", level, 0);
        wait_phase(20);
        for (int i = 0; i < 3; i++) write(DB'($urandom), DB'($urandom));
        check("three frames queued", level, 3);
        wait_phase(90);
        check("in left slot before reset", ws, 0);
        arst = 1'b1;
        tick(1);
        check("mid-frame reset outputs", {bck, ws, sdata, und, ovf, level}, 0);
        arst = 1'b0;
        u0 = und_cnt;
        wait_phase(PRE_FRAME);
        wait_phase(PRE_FRAME);
        check_frame("frame after reset", 0, '0, '0);
        check("underrun after mid-frame reset", 64'(und_cnt - u0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
